// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes and vector addresses.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] VEC_GENERAL = 32'hBFC0_0380;
    localparam logic [31:0] VEC_INT     = 32'hBFC0_0400;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with clock prescaler and sticky timer-interrupt flag.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic        count_wen_i,
    input  logic        compare_wen_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_wen_i) begin
            count_d = wdata_i;
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            count_d = count_q + 32'd1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        if (compare_wen_i) compare_d = wdata_i;
        if (count_q == compare_q) ti_d = 1'b1;
        // a Compare write acknowledges the interrupt even if the match persists
        if (compare_wen_i) ti_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: Status/Cause/EPC/BadVAddr, interrupt detection and vectoring.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int HW_INT_W   = 6,
    parameter int COUNT_DIV  = 2,
    parameter int INT_VEC_EN = 0
) (
    input  logic                clk,
    input  logic                rst_p,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                ma_valid,
    input  logic                ma_leaving,
    input  logic [4:0]          ma_exccode,
    input  logic                ma_eret,
    input  logic                ma_bd,
    input  logic [31:0]         ma_pc,
    input  logic [31:0]         ma_badvaddr,
    input  logic                wb_enable,
    output logic                exception,
    output logic [31:0]         handler_entry,
    output logic [31:0]         epc_out,
    output logic                timer_int,
    input  logic [4:0]          cp0_raddr,
    output logic [31:0]         cp0_rdata,
    input  logic                cp0_wen,
    input  logic [4:0]          cp0_waddr,
    input  logic [31:0]         cp0_wdata
);

    logic [HW_INT_W-1:0] sync1_q, sync2_q;
    logic [7:0]  im_q;
    logic        exl_q, ie_q;
    logic        bd_q, iv_q;
    logic [1:0]  ipsw_q;
    logic [4:0]  exc_q;
    logic [31:0] epc_q, badvaddr_q;

    logic [31:0] count, compare;
    logic        ti;
    logic [5:0]  hw6;
    logic [7:0]  ip;
    logic        int_taken;
    logic        eret_ret;
    logic        mtc0_ok;

    assign hw6       = 6'(sync2_q);
    assign ip        = {hw6[5] | ti, hw6[4:0], ipsw_q};
    assign int_taken = ie_q && !exl_q && ((ip & im_q) != 8'd0);
    assign exception = wb_enable && ma_valid && (int_taken || (ma_exccode != 5'd0));
    assign eret_ret  = ma_eret && ma_leaving;
    // MTC0 loses to both an exception and a retiring ERET in the same cycle
    assign mtc0_ok   = cp0_wen && ma_leaving && !exception && !eret_ret;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk           (clk),
        .rst_p         (rst_p),
        .count_wen_i   (mtc0_ok && (cp0_waddr == CP0_COUNT)),
        .compare_wen_i (mtc0_ok && (cp0_waddr == CP0_COMPARE)),
        .wdata_i       (cp0_wdata),
        .count_o       (count),
        .compare_o     (compare),
        .ti_o          (ti)
    );

    always_ff @(posedge clk) begin
        if (rst_p) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            iv_q       <= 1'b0;
            ipsw_q     <= '0;
            exc_q      <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            sync1_q <= hw_int;
            sync2_q <= sync1_q;
            if (exception) begin
                if (!exl_q) begin
                    epc_q <= ma_bd ? (ma_pc - 32'd4) : ma_pc;
                    bd_q  <= ma_bd;
                end
                exl_q <= 1'b1;
                exc_q <= int_taken ? EXC_INT : ma_exccode;
                if (!int_taken && is_addr_exc(ma_exccode)) badvaddr_q <= ma_badvaddr;
            end else if (eret_ret) begin
                exl_q <= 1'b0;
            end else if (mtc0_ok) begin
                case (cp0_waddr)
                    CP0_STATUS: begin
                        im_q  <= cp0_wdata[15:8];
                        exl_q <= cp0_wdata[1];
                        ie_q  <= cp0_wdata[0];
                    end
                    CP0_CAUSE: begin
                        ipsw_q <= cp0_wdata[9:8];
                        if (INT_VEC_EN != 0) iv_q <= cp0_wdata[23];
                    end
                    CP0_EPC: epc_q <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
            CP0_CAUSE:    cp0_rdata = {bd_q, ti, 6'd0, iv_q, 7'd0, ip, 1'b0, exc_q, 2'd0};
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign handler_entry = ((INT_VEC_EN != 0) && iv_q && int_taken) ? VEC_INT : VEC_GENERAL;
    assign epc_out       = epc_q;
    assign timer_int     = ti;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit (COUNT_DIV=1 with vectoring, plus a COUNT_DIV=4 copy).
module tb_cp0_exc_unit;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst_p = 1'b1;
    logic [5:0]  hw_int = '0;
    logic        ma_valid = 1'b0, ma_leaving = 1'b0, ma_eret = 1'b0, ma_bd = 1'b0;
    logic [4:0]  ma_exccode = '0;
    logic [31:0] ma_pc = '0, ma_badvaddr = '0;
    logic        wb_enable = 1'b1;
    logic [4:0]  cp0_raddr = '0, cp0_waddr = '0;
    logic        cp0_wen = 1'b0;
    logic [31:0] cp0_wdata = '0;

    logic        exception, timer_int, exception4, timer_int4;
    logic [31:0] handler_entry, epc_out, cp0_rdata;
    logic [31:0] handler_entry4, epc_out4, cp0_rdata4;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] v, v4;

    always #5 clk = ~clk;

    cp0_exc_unit #(.HW_INT_W(6), .COUNT_DIV(1), .INT_VEC_EN(1)) dut (
        .clk(clk), .rst_p(rst_p), .hw_int(hw_int), .ma_valid(ma_valid), .ma_leaving(ma_leaving),
        .ma_exccode(ma_exccode), .ma_eret(ma_eret), .ma_bd(ma_bd), .ma_pc(ma_pc),
        .ma_badvaddr(ma_badvaddr), .wb_enable(wb_enable), .exception(exception),
        .handler_entry(handler_entry), .epc_out(epc_out), .timer_int(timer_int),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .cp0_wen(cp0_wen),
        .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata)
    );

    cp0_exc_unit #(.HW_INT_W(6), .COUNT_DIV(4), .INT_VEC_EN(0)) dut4 (
        .clk(clk), .rst_p(rst_p), .hw_int(hw_int), .ma_valid(ma_valid), .ma_leaving(ma_leaving),
        .ma_exccode(ma_exccode), .ma_eret(ma_eret), .ma_bd(ma_bd), .ma_pc(ma_pc),
        .ma_badvaddr(ma_badvaddr), .wb_enable(wb_enable), .exception(exception4),
        .handler_entry(handler_entry4), .epc_out(epc_out4), .timer_int(timer_int4),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata4), .cp0_wen(cp0_wen),
        .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_wen = 1'b1; ma_valid = 1'b1; ma_leaving = 1'b1; cp0_waddr = a; cp0_wdata = d;
        tick();
        cp0_wen = 1'b0; ma_valid = 1'b0; ma_leaving = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        cp0_raddr = a;
        #1;
        v  = cp0_rdata;
        v4 = cp0_rdata4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, sampled while reset is still held
        repeat (3) tick();
        chk("rst_timer_int", {31'd0, timer_int}, 32'd0);
        chk("rst_epc_out", epc_out, 32'd0);
        chk("rst_handler", handler_entry, 32'hBFC0_0380);
        rd(CP0_STATUS);
        chk("rst_status_bev", v, 32'h0040_0000);
        rst_p = 1'b0;

        // Count wrap at COUNT_DIV=4 (dut4) and COUNT_DIV=1 (dut)
        mtc0(CP0_COUNT, 32'hFFFF_FFFE);
        repeat (3) tick();
        rd(CP0_COUNT);
        chk("div4_count_3clk", v4, 32'hFFFF_FFFE);
        tick();
        rd(CP0_COUNT);
        chk("div4_count_4clk", v4, 32'hFFFF_FFFF);
        repeat (4) tick();
        rd(CP0_COUNT);
        chk("div4_count_8clk", v4, 32'h0000_0000);
        chk("div1_count_8clk", v, 32'h0000_0006);

        // Timer interrupt: Compare=10, Count=5 at COUNT_DIV=1
        mtc0(CP0_COMPARE, 32'd10);
        chk("ti_cleared_by_compare", {31'd0, timer_int}, 32'd0);
        mtc0(CP0_COUNT, 32'd5);
        repeat (4) tick();
        chk("ti_before_match", {31'd0, timer_int}, 32'd0);
        repeat (2) tick();
        chk("ti_after_match", {31'd0, timer_int}, 32'd1);
        rd(CP0_CAUSE);
        chk("cause_ti_bit", {31'd0, v[30]}, 32'd1);
        mtc0(CP0_COMPARE, 32'h100);
        chk("ti_clear_write", {31'd0, timer_int}, 32'd0);

        // Hardware interrupt through the synchroniser
        mtc0(CP0_STATUS, 32'h0000_0401);
        rd(CP0_STATUS);
        chk("status_rb", v, 32'h0040_0401);
        ma_pc = 32'h2000; ma_valid = 1'b1; ma_leaving = 1'b1; hw_int = 6'b000001;
        #1 chk("int_exc_0clk", {31'd0, exception}, 32'd0);
        tick();
        chk("int_exc_1clk", {31'd0, exception}, 32'd0);
        tick();
        chk("int_exc_2clk", {31'd0, exception}, 32'd1);
        chk("int_handler_noiv", handler_entry, 32'hBFC0_0380);
        tick();
        chk("int_exc_after_exl", {31'd0, exception}, 32'd0);
        rd(CP0_EPC);
        chk("int_epc", v, 32'h2000);
        rd(CP0_CAUSE);
        chk("int_exccode", (v >> 2) & 32'h1F, 32'd0);
        chk("int_ip2", {31'd0, v[10]}, 32'd1);
        rd(CP0_STATUS);
        chk("int_exl_set", v, 32'h0040_0403);
        hw_int = '0; ma_valid = 1'b0; ma_eret = 1'b1;
        tick();
        ma_eret = 1'b0; ma_leaving = 1'b0;
        rd(CP0_STATUS);
        chk("eret_exl_clr", v, 32'h0040_0401);
        repeat (2) tick();

        // Dedicated interrupt vector only where INT_VEC_EN=1
        mtc0(CP0_CAUSE, 32'h0080_0000);
        rd(CP0_CAUSE);
        chk("iv_written", {31'd0, v[23]}, 32'd1);
        chk("iv_not_impl", {31'd0, v4[23]}, 32'd0);
        hw_int = 6'b000001;
        repeat (2) tick();
        chk("handler_iv", handler_entry, 32'hBFC0_0400);
        chk("handler_noivimpl", handler_entry4, 32'hBFC0_0380);
        wb_enable = 1'b0; ma_valid = 1'b1;
        #1 chk("exc_wb_blocked", {31'd0, exception}, 32'd0);
        wb_enable = 1'b1;
        #1 chk("exc_wb_ok", {31'd0, exception}, 32'd1);
        ma_valid = 1'b0; hw_int = '0;
        repeat (3) tick();
        mtc0(CP0_STATUS, 32'd0);
        mtc0(CP0_CAUSE, 32'd0);

        // Address error in a delay slot
        ma_valid = 1'b1; ma_leaving = 1'b1; ma_exccode = EXC_ADEL; ma_bd = 1'b1;
        ma_pc = 32'h100; ma_badvaddr = 32'h203;
        #1 chk("ade_exc", {31'd0, exception}, 32'd1);
        tick();
        ma_valid = 1'b0; ma_leaving = 1'b0; ma_exccode = '0; ma_bd = 1'b0;
        chk("ade_epc", epc_out, 32'hFC);
        rd(CP0_CAUSE);
        chk("ade_bd", {31'd0, v[31]}, 32'd1);
        chk("ade_exccode", (v >> 2) & 32'h1F, 32'd4);
        rd(CP0_BADVADDR);
        chk("ade_badvaddr", v, 32'h203);
        rd(CP0_STATUS);
        chk("ade_exl", {31'd0, v[1]}, 32'd1);

        // Nested exception with a colliding MTC0 to EPC
        ma_valid = 1'b1; ma_leaving = 1'b1; ma_exccode = EXC_OV; ma_pc = 32'h300;
        ma_badvaddr = 32'h999; cp0_wen = 1'b1; cp0_waddr = CP0_EPC; cp0_wdata = 32'hDEAD_0000;
        tick();
        ma_valid = 1'b0; ma_exccode = '0; cp0_wen = 1'b0;
        chk("nest_epc_hold", epc_out, 32'hFC);
        rd(CP0_CAUSE);
        chk("nest_bd_hold", {31'd0, v[31]}, 32'd1);
        chk("nest_exccode", (v >> 2) & 32'h1F, 32'd12);
        rd(CP0_BADVADDR);
        chk("nest_badv_hold", v, 32'h203);

        // ERET beats a same-cycle MTC0
        ma_eret = 1'b1; cp0_wen = 1'b1; cp0_waddr = CP0_EPC; cp0_wdata = 32'h1234;
        tick();
        ma_eret = 1'b0; cp0_wen = 1'b0; ma_leaving = 1'b0;
        rd(CP0_STATUS);
        chk("eret2_exl_clr", {31'd0, v[1]}, 32'd0);
        chk("eret2_epc_hold", epc_out, 32'hFC);
        mtc0(CP0_EPC, 32'h55AA);
        chk("epc_mtc0", epc_out, 32'h55AA);
        rd(5'd3);
        chk("unimpl_reg", v, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
